// File: rtl/lsu_pkg.sv
// Shared opcodes, FSM state encoding and op-classification helpers for the
// load/store unit.
package lsu_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
               (op == OP_SW) || (op == OP_SB);
    endfunction

    function automatic logic op_is_word(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-result formatter: picks the addressed byte and
// sign/zero-extends it, or passes a whole word through; non-loads give 0.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_word,
    output logic [31:0] o_rdata
);

    logic [7:0] w_byte;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_byte = i_word[7:0];
        case (i_byte_off)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
    end

    always_comb begin
        o_rdata = '0;
        case (i_op)
            OP_LW:   o_rdata = i_word;
            OP_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_rdata = {24'd0, w_byte};
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: IDLE -> REQ -> DONE handshake FSM over a req/ack word bus.
// Optional macro ALIGN_CHECK_EN rejects misaligned lw/sw without a bus cycle.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int AW      = 12,
    parameter int TIMEOUT = 15
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_valid,
    output logic          cpu_ready,
    input  logic [5:0]    cpu_op,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          done_valid,
    input  logic          done_ready,
    output logic [31:0]   done_rdata,
    output logic          done_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);

    state_t         r_state, w_next;
    logic [5:0]     r_op;
    logic [1:0]     r_off;
    logic [AW-3:0]  r_waddr;
    logic [3:0]     r_be;
    logic           r_we;
    logic [31:0]    r_wdata;
    logic [3:0]     r_timer;
    logic [31:0]    r_rdata;
    logic           r_err;

    logic           w_accept, w_go_req, w_misalign, w_expire;
    logic [3:0]     w_be, w_onehot;
    logic           w_we;
    logic [31:0]    w_wdata, w_load;
    logic           w_unused_addr;

    assign w_unused_addr = ^cpu_addr[31:AW];

    assign w_accept = cpu_valid && (r_state == IDLE);
`ifdef ALIGN_CHECK_EN
    assign w_misalign = op_is_word(cpu_op) && (cpu_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif
    assign w_go_req = w_accept && op_supported(cpu_op) && !w_misalign;
    // Ack on the final allowed cycle wins over the timeout.
    assign w_expire = (r_state == REQ) && !mem_ack && (r_timer == 4'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_go_req ? REQ : DONE;
            REQ:     if (mem_ack || w_expire) w_next = DONE;
            DONE:    if (done_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_onehot = 4'b0001 << cpu_addr[1:0];

    always_comb begin
        w_be    = '0;
        w_we    = 1'b0;
        w_wdata = '0;
        case (cpu_op)
            OP_SW:        begin w_be = 4'b1111;  w_we = 1'b1; w_wdata = cpu_wdata; end
            OP_SB:        begin w_be = w_onehot; w_we = 1'b1; w_wdata = {4{cpu_wdata[7:0]}}; end
            OP_LW:        w_be = 4'b1111;
            OP_LB, OP_LBU: w_be = w_onehot;
            default:      w_be = '0;
        endcase
    end

    lsu_load_align u_align (
        .i_op       (r_op),
        .i_byte_off (r_off),
        .i_word     (mem_rdata),
        .o_rdata    (w_load)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_off   <= '0;
            r_waddr <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_timer <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_go_req) begin
                r_op    <= cpu_op;
                r_off   <= cpu_addr[1:0];
                r_waddr <= cpu_addr[AW-1:2];
                r_be    <= w_be;
                r_we    <= w_we;
                r_wdata <= w_wdata;
            end else if ((r_state == REQ) && (w_next == DONE)) begin
                r_be <= '0;
            end

            if ((r_state == REQ) && (w_next == REQ)) r_timer <= r_timer + 4'd1;
            else                                     r_timer <= '0;

            if (w_accept && !w_go_req) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end else if ((r_state == REQ) && mem_ack) begin
                r_err   <= 1'b0;
                r_rdata <= w_load;
            end else if (w_expire) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end else if ((r_state == DONE) && done_ready) begin
                r_err   <= 1'b0;
                r_rdata <= '0;
            end
        end
    end

    assign cpu_ready  = (r_state == IDLE);
    assign done_valid = (r_state == DONE);
    assign done_rdata = r_rdata;
    assign done_err   = r_err;
    assign mem_req    = (r_state == REQ);
    assign mem_we     = r_we;
    assign mem_addr   = r_waddr;
    assign mem_be     = r_be;
    assign mem_wdata  = r_wdata;

endmodule
